// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch run/pause/clear/adjust sequencer.
// Optional lap-hold build: define LAP_HOLD_EN (see stopwatch_ctrl.sv).
package stopwatch_pkg;

  // Controller state encodings (also driven onto the debug LEDs)
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] PAUSE = 2'd1;
  localparam logic [1:0] ADJ   = 2'd2;

  // Field select switch polarity
  localparam logic SEL_MIN = 1'b1;
  localparam logic SEL_SEC = 1'b0;

  // 10 ms of stability at 100 MHz; width must satisfy 2**DEF_DB_W > DEF_DB_CYCLES
  localparam int unsigned DEF_DB_CYCLES = 1000000;
  localparam int unsigned DEF_DB_W      = 20;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Strobe/blanking bundle from the stopwatch sequencer to the counter and
// the 7-segment driver. With LAP_HOLD_EN defined it also carries disp_hold.
interface stopwatch_ctrl_if;

  logic       cnt_inc;
  logic       cnt_clr;
  logic       adj_min_inc;
  logic       adj_sec_inc;
  logic       blank_min;
  logic       blank_sec;
  logic [1:0] state_o;
`ifdef LAP_HOLD_EN
  logic       disp_hold;
`endif

  // Sequencer side
  modport master (
    output cnt_inc,
    output cnt_clr,
    output adj_min_inc,
    output adj_sec_inc,
    output blank_min,
    output blank_sec,
`ifdef LAP_HOLD_EN
    output disp_hold,
`endif
    output state_o
  );

  // Counter / display side
  modport slave (
    input cnt_inc,
    input cnt_clr,
    input adj_min_inc,
    input adj_sec_inc,
    input blank_min,
    input blank_sec,
`ifdef LAP_HOLD_EN
    input disp_hold,
`endif
    input state_o
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stable-count debouncer and a
// registered one-cycle pulse on each rising edge of the debounced level.
// Raw edge to pulse is 2 + DB_CYCLES + 1 clk cycles.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
  parameter int unsigned DB_W      = DEF_DB_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync;
  logic            lvl;
  logic            lvl_d;
  logic [DB_W-1:0] cnt;

  // Bring the raw button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], btn};
  end

  // Flip the level only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (sync[1] == lvl) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      lvl <= sync[1];
      cnt <= '0;
    end else begin
      cnt <= cnt + DB_W'(1);
    end
  end

  // One-cycle pulse on the debounced rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d <= 1'b0;
      press <= 1'b0;
    end else begin
      lvl_d <= lvl;
      press <= lvl & ~lvl_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear/adjust sequencer. Conditions the board buttons
// and switches, then issues registered one-cycle strobes to the mm:ss
// counter and blank masks to the display driver.
// Optional feature macro: LAP_HOLD_EN (adds btn_lap input and disp_hold).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
  parameter int unsigned DB_W      = DEF_DB_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic unit_tick,
  input  logic fast_tick,
  input  logic blink_lvl,
  input  logic btn_pause,
  input  logic btn_clr,
  input  logic sw_adj,
  input  logic sw_sel,
`ifdef LAP_HOLD_EN
  input  logic btn_lap,
`endif
  stopwatch_ctrl_if.master cnt_bus
);

  logic       pause_p;
  logic       clr_p;
  logic [1:0] adj_sync;
  logic [1:0] sel_sync;
  logic       sw_adj_s;
  logic       sw_sel_s;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] saved_state;
  logic [1:0] saved_nxt;
  logic       inc_q,  inc_nxt;
  logic       clr_q,  clr_nxt;
  logic       min_q,  min_nxt;
  logic       sec_q,  sec_nxt;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_pause),
    .press (pause_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .press (clr_p)
  );

  // Switches are level controls: synchronise only, no debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj_sync <= '0;
      sel_sync <= '0;
    end else begin
      adj_sync <= {adj_sync[0], sw_adj};
      sel_sync <= {sel_sync[0], sw_sel};
    end
  end

  assign sw_adj_s = adj_sync[1];
  assign sw_sel_s = sel_sync[1];

  // Next state and next strobes; clear overrides every increment
  always_comb begin
    state_nxt = state;
    saved_nxt = saved_state;
    inc_nxt   = 1'b0;
    clr_nxt   = clr_p;
    min_nxt   = 1'b0;
    sec_nxt   = 1'b0;
    case (state)
      RUN: begin
        inc_nxt = unit_tick;
        if (sw_adj_s) begin
          saved_nxt = RUN;
          state_nxt = ADJ;
        end else if (pause_p) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (sw_adj_s) begin
          saved_nxt = PAUSE;
          state_nxt = ADJ;
        end else if (pause_p) begin
          state_nxt = RUN;
        end
      end
      ADJ: begin
        if (fast_tick) begin
          min_nxt = (sw_sel_s == SEL_MIN);
          sec_nxt = (sw_sel_s == SEL_SEC);
        end
        if (!sw_adj_s) state_nxt = saved_state;
      end
      default: state_nxt = PAUSE;
    endcase
    if (clr_p) begin
      inc_nxt = 1'b0;
      min_nxt = 1'b0;
      sec_nxt = 1'b0;
    end
  end

  // State and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      saved_state <= RUN;
      inc_q       <= 1'b0;
      clr_q       <= 1'b0;
      min_q       <= 1'b0;
      sec_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      saved_state <= saved_nxt;
      inc_q       <= inc_nxt;
      clr_q       <= clr_nxt;
      min_q       <= min_nxt;
      sec_q       <= sec_nxt;
    end
  end

`ifdef LAP_HOLD_EN
  logic lap_p;
  logic hold_q;
  logic hold_nxt;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lap (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_lap),
    .press (lap_p)
  );

  // Lap toggles only while running; leaving RUN or clearing drops the hold
  always_comb begin
    hold_nxt = hold_q;
    if (state == RUN && lap_p) hold_nxt = ~hold_q;
    if (state_nxt != state && (state_nxt == PAUSE || state_nxt == ADJ)) hold_nxt = 1'b0;
    if (clr_p) hold_nxt = 1'b0;
  end

  // Display hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else        hold_q <= hold_nxt;
  end

  assign cnt_bus.disp_hold = hold_q;
`endif

  assign cnt_bus.cnt_inc     = inc_q;
  assign cnt_bus.cnt_clr     = clr_q;
  assign cnt_bus.adj_min_inc = min_q;
  assign cnt_bus.adj_sec_inc = sec_q;
  assign cnt_bus.state_o     = state;

  // Blink the field being adjusted; state resets to RUN so blanks are 0 in reset
  assign cnt_bus.blank_min = (state == ADJ) & (sw_sel_s == SEL_MIN) & blink_lvl;
  assign cnt_bus.blank_sec = (state == ADJ) & (sw_sel_s == SEL_SEC) & blink_lvl;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/clear/adjust sequencer for the minute:second stopwatch counter on the Nexys3 board. It takes raw board buttons and switches plus one-cycle tick strobes from the clock divider. It produces single-cycle increment and clear strobes for the counter and blank masks for the 7-segment display driver. The counter becomes a synchronous, enable-driven datapath clocked by clk; this block decides when it advances.

Parameters:
DB_CYCLES, 1000000, consecutive stable clk cycles required before a debounced button changes level (10 ms at 100 MHz)
DB_W, 20, width of the debounce counter; must satisfy 2**DB_W > DB_CYCLES

Ports:
clk  input  1  100 MHz system clock
rst_n  input  1  asynchronous active-low reset
unit_tick  input  1  one-cycle strobe at 1 Hz, synchronous to clk
fast_tick  input  1  one-cycle strobe at 2 Hz, synchronous to clk
blink_lvl  input  1  blink square wave (~4 Hz level), synchronous to clk
btn_pause  input  1  raw pause button, asynchronous, active-high
btn_clr  input  1  raw clear button, asynchronous, active-high
sw_adj  input  1  raw adjust-mode switch, asynchronous
sw_sel  input  1  raw field select: 1 = minutes, 0 = seconds
cnt_inc  output  1  one-cycle strobe: advance the counter by one second
cnt_clr  output  1  one-cycle strobe: set the counter to 00:00
adj_min_inc  output  1  one-cycle strobe: minutes +1 (wraps 59->00, no carry)
adj_sec_inc  output  1  one-cycle strobe: seconds +1 (wraps 59->00, no carry)
blank_min  output  1  display blanks the minute digits while high
blank_sec  output  1  display blanks the second digits while high
state_o  output  2  current state encoding, for debug LEDs

Behaviour:
- Reset: rst_n is asynchronous and active-low. While low, all outputs are 0, state = RUN, saved_state = RUN, synchronisers = 0, debounce levels = 0, counters = 0.
- Input conditioning:
  - All four raw inputs pass through a 2-flop synchroniser.
  - Each button then feeds a debouncer. The internal level flips only after the synced input has differed from it for DB_CYCLES consecutive cycles. Any return to the current level resets the count.
  - A press pulse (pause_p, clr_p) is asserted for one cycle on the rising edge of the debounced level.
  - Raw-edge to pulse latency = 2 + DB_CYCLES + 1 cycles. Holding a button yields exactly one pulse.
  - Switches are synchronised only; they are not debounced.
- States: RUN=2'd0, PAUSE=2'd1, ADJ=2'd2; 2'd3 is illegal and recovers to PAUSE on the next cycle.
  - RUN: cnt_inc = unit_tick. pause_p -> PAUSE.
  - PAUSE: cnt_inc = 0. pause_p -> RUN.
  - Any state except ADJ, with sw_adj_s = 1: saved_state <= current state, then -> ADJ.
  - ADJ: cnt_inc = 0 and pause_p is ignored. On fast_tick, adj_min_inc = sw_sel_s and adj_sec_inc = !sw_sel_s. When sw_adj_s = 0, return to saved_state.
- Clear: clr_p asserts cnt_clr for one cycle in every state and does not change state.
- Outputs: cnt_inc, cnt_clr, adj_min_inc and adj_sec_inc are registered, giving 1-cycle latency from tick/pulse to strobe.
- Blanking: in ADJ, blank_min = sw_sel_s & blink_lvl and blank_sec = !sw_sel_s & blink_lvl. Outside ADJ, both are 0.
- Simultaneous events:
  - cnt_clr and any increment strobe in the same cycle: clear wins and all increment strobes are forced to 0.
  - pause_p together with unit_tick in RUN: the tick is honoured (cnt_inc = 1) and the state becomes PAUSE.
  - pause_p in the same cycle sw_adj_s rises: ADJ entry wins, pause_p is dropped, and saved_state takes the pre-press state.
- Reset mid-debounce discards partial counts. Strobes never stretch beyond one cycle.

Optional Feature:
LAP_HOLD_EN
- Defined:
  - Adds input btn_lap (raw, debounced like the other buttons) and output disp_hold.
  - In RUN, lap_p toggles disp_hold; the display driver freezes its latched value while disp_hold = 1, and counting continues.
  - disp_hold is forced to 0 on entry to PAUSE or ADJ, on cnt_clr, and on reset.
- Undefined: btn_lap and disp_hold do not exist, and no lap logic is synthesised.

Decomposition:
- Package stopwatch_pkg:
  - state encodings RUN/PAUSE/ADJ
  - SEL_MIN=1'b1 and SEL_SEC=1'b0
  - default DB_CYCLES constant
- One sub-module, btn_debounce (sync + stable counter + rising-edge pulse), parameterised by DB_CYCLES/DB_W. It is instantiated for pause and clr, plus lap when LAP_HOLD_EN is defined.

Test Plan:
All scenarios use DB_CYCLES=4.
1. Reset then 3 unit_tick strobes → exactly 3 single-cycle cnt_inc pulses, each 1 cycle after its tick; state_o=0.
2. btn_pause held high 20 cycles with a 2-cycle bounce at start → exactly one pause_p, state_o 0→1; subsequent unit_ticks give cnt_inc=0; a second clean press returns state_o to 0.
3. btn_pause glitch of 3 cycles → no state change.
4. From PAUSE, sw_adj=1, sw_sel=1, 4 fast_tick strobes, blink_lvl toggling → 4 adj_min_inc pulses, adj_sec_inc=0, blank_min follows blink_lvl, blank_sec=0. Then sw_adj=0 → state_o returns to 1 (PAUSE).
5. btn_clr press landing on the same cycle as a unit_tick in RUN → cnt_clr=1, cnt_inc=0 that cycle, state stays RUN.
6. rst_n low for one cycle mid-debounce, with state=PAUSE and a strobe pending → all outputs 0 immediately (asynchronous), state_o=0 after release, no stray pulse afterwards.
